// File: rtl/strobe_sched_pkg.sv
// strobe_sched_pkg: shared FSM state encoding, counter width and arbitration helpers.
// Contents: state_t (IDLE/SETUP/STROBE/HOLD), CNT_W, rr_pick(), prio_pick().
// Used by: strobe_sched.
package strobe_sched_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // Round-robin: the first set bit strictly after 'last', searching upward and wrapping.
    // k runs 1..8, so the last candidate examined is 'last' itself.
    function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] last);
        logic [2:0] idx;
        logic [2:0] win;
        logic       found;
        win   = last;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            idx = last + 3'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    // Fixed priority: the lowest set index wins.
    function automatic logic [2:0] prio_pick(input logic [7:0] req);
        logic [2:0] win;
        logic       found;
        win   = 3'd0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!found && req[i]) begin
                win   = 3'(i);
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/x74138.sv
// x74138: 3-to-8 line decoder with one active-high and two active-low enables.
// Ports: a (select), g1 / g2a_n / g2b_n (enables), y_n (active-low one-hot out).
// Purely combinational; all outputs are high whenever any enable is inactive.
module x74138 (
    input  logic [2:0] a,
    input  logic       g1,
    input  logic       g2a_n,
    input  logic       g2b_n,
    output logic [7:0] y_n
);

    always_comb begin
        y_n = 8'hFF;
        if (g1 && !g2a_n && !g2b_n) begin
            y_n = ~(8'd1 << a);
        end
    end

endmodule

// File: rtl/strobe_sched.sv
// strobe_sched: arbitrates 8 level requests and runs a SETUP/STROBE/HOLD chip-select cycle.
// Ports: clk, reset_n (async, active-low), req[7:0] in; sel, g1, g2a_n, g2b_n, cs_n, ack, busy out.
// Macro STROBE_SCHED_FIXED_PRIO_EN selects fixed priority instead of round-robin; timing is unchanged.
module strobe_sched
    import strobe_sched_pkg::*;
#(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] req,
    output logic [2:0] sel,
    output logic       g1,
    output logic       g2a_n,
    output logic       g2b_n,
    output logic [7:0] cs_n,
    output logic [7:0] ack,
    output logic       busy
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [2:0]       winner;
    logic             grant;

    // A grant happens only from IDLE; req is ignored in every other state.
    assign grant = (state == ST_IDLE) && (|req);

`ifdef STROBE_SCHED_FIXED_PRIO_EN
    assign winner = prio_pick(req);
`else
    logic [2:0] last;

    assign winner = rr_pick(req, last);

    // Reset value 7 makes index 0 the first candidate after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last <= 3'd7;
        end else if (grant) begin
            last <= winner;
        end
    end
`endif

    // Each phase counter loads its length on entry and leaves the phase when it reaches 1.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_IDLE: begin
                if (grant) begin
                    state_nx = ST_SETUP;
                    cnt_nx   = CNT_W'(SETUP_CYC);
                end
            end
            ST_SETUP: begin
                if (cnt == CNT_ONE) begin
                    state_nx = ST_STROBE;
                    cnt_nx   = CNT_W'(STROBE_CYC);
                end else begin
                    cnt_nx = cnt - CNT_ONE;
                end
            end
            ST_STROBE: begin
                if (cnt == CNT_ONE) begin
                    state_nx = ST_HOLD;
                    cnt_nx   = CNT_W'(HOLD_CYC);
                end else begin
                    cnt_nx = cnt - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (cnt == CNT_ONE) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt - CNT_ONE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Enables and ack are registered from the next-state decode so they line up
    // exactly with the state they belong to. sel only changes on a grant, so it
    // is already stable when ack is built from it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            sel   <= 3'd0;
            g1    <= 1'b0;
            g2a_n <= 1'b1;
            g2b_n <= 1'b1;
            ack   <= 8'h00;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (grant) begin
                sel <= winner;
            end
            g1    <= (state_nx == ST_STROBE);
            g2a_n <= (state_nx != ST_STROBE);
            g2b_n <= (state_nx != ST_STROBE);
            if ((state_nx == ST_HOLD) && (cnt_nx == CNT_ONE)) begin
                ack <= 8'd1 << sel;
            end else begin
                ack <= 8'h00;
            end
        end
    end

    assign busy = (state != ST_IDLE);

    x74138 u_dec (
        .a     (sel),
        .g1    (g1),
        .g2a_n (g2a_n),
        .g2b_n (g2b_n),
        .y_n   (cs_n)
    );

endmodule

// File: doc/strobe_sched.md
STROBE_SCHED -- requirements
Module: strobe_sched

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 1: cycles select is stable before the strobe; legal 1..15.
REQ-002 SHALL have parameter STROBE_CYC, default 2: cycles the chip-select strobe is active; legal 1..15.
REQ-003 SHALL have parameter HOLD_CYC, default 1: cycles select is held after the strobe; legal 1..15.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, with all state changing on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port req, input, 8 bits: level request per requester, active high.
REQ-007 SHALL have port sel, output, 3 bits: registered binary index of the granted requester (decoder A input).
REQ-008 SHALL have port g1, output, 1 bit: registered decoder enable, active high.
REQ-009 SHALL have port g2a_n, output, 1 bit: registered decoder enable, active low.
REQ-010 SHALL have port g2b_n, output, 1 bit: registered decoder enable, active low.
REQ-011 SHALL have port cs_n, output, 8 bits: decoded active-low one-hot chip select.
REQ-012 SHALL have port ack, output, 8 bits: one-cycle completion pulse, one-hot.
REQ-013 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, SETUP, STROBE and HOLD.
REQ-015 SHALL, in IDLE with any req bit set, latch the arbitration winner into sel and move to SETUP at the next edge.
REQ-016 SHALL stay in SETUP for SETUP_CYC cycles with enables inactive (g1=0, g2a_n=1, g2b_n=1).
REQ-017 SHALL stay in STROBE for STROBE_CYC cycles with g1=1, g2a_n=0, g2b_n=0, so cs_n[sel]=0 and all other cs_n bits are 1.
REQ-018 SHALL stay in HOLD for HOLD_CYC cycles with enables inactive and sel unchanged.
REQ-019 SHALL assert ack[sel] in the last HOLD cycle only, then return to IDLE.
REQ-020 SHALL spend exactly one cycle in IDLE between transactions, giving a back-to-back grant period of SETUP_CYC+STROBE_CYC+HOLD_CYC+1 cycles.
REQ-021 SHALL arbitrate round-robin: the winner is the first set req bit strictly after the last-granted index, searching upward and wrapping 7 -> 0.
REQ-022 SHALL update the last-granted pointer only on a grant in IDLE.
REQ-023 SHALL sample req only in IDLE; a request dropped mid-transaction does not abort it, and the ack is still issued.
REQ-024 SHALL re-arbitrate a request that is still held after its ack like any other request; it gets no immediate repeat if others are pending.
REQ-025 SHALL hold sel unchanged in IDLE, with enables inactive.
REQ-026 SHALL use 4-bit phase counters that load at state entry and count down to 1.
REQ-027 SHALL produce cs_n combinationally from the registered sel, g1, g2a_n and g2b_n only.

Reset
REQ-028 SHALL, while reset_n is low, asynchronously force: state=IDLE, sel=0, g1=0, g2a_n=1, g2b_n=1, cs_n=8'hFF, ack=0, busy=0, counters=0, last-granted pointer=7.
REQ-029 SHALL, on reset mid-transaction, drop the strobe immediately, issue no ack, and discard the transaction.
REQ-030 SHALL allow the first grant at the first rising edge after reset_n deasserts.

Configuration
REQ-031 SHALL, with macro STROBE_SCHED_FIXED_PRIO_EN defined, use fixed priority (lowest set index wins) and remove the pointer register.
REQ-032 SHALL, without STROBE_SCHED_FIXED_PRIO_EN defined, use round-robin per REQ-021; all timing is identical in both builds.

Structure
REQ-033 SHALL define the FSM state enum and the counter width constant (4) in the shared package strobe_sched_pkg.
REQ-034 SHALL instantiate the existing x74138 decoder once for cs_n; no other sub-module.

Verification (defaults S=1, W=2, H=1)
REQ-035 SHALL cover a single request: req=8'h04 from reset -> sel=2 after 1 cycle, cs_n=8'hFB for 2 cycles, ack=8'h04 for 1 cycle, busy low on cycle 5.
REQ-036 SHALL cover all requesters held: req=8'hFF -> grant order 0,1,...,7,0 with period 5 cycles.
REQ-037 SHALL cover withdrawal: req=8'h10 pulsed for 1 cycle -> full transaction, ack=8'h10, no second grant.
REQ-038 SHALL cover reset mid-strobe: reset_n low during STROBE -> cs_n=8'hFF in the same cycle, ack stays 0, next grant restarts from index 0.
REQ-039 SHALL cover the fixed-priority build: req=8'h81 held -> index 0 granted repeatedly, index 7 never granted.
REQ-040 SHALL cover mutual exclusion: random req for 10k cycles -> cs_n never has more than one bit low, and each ack follows its own strobe.
